fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the 16-bit synchronous `Memory` block. It owns the program counter and issues word reads to memory. It captures the one-cycle-latency read data into a 2-entry prefetch buffer and presents instructions to the decoder through a valid/ready handshake. It also supports a branch redirect that flushes buffered and in-flight fetches, and freezes together with memory while `i_halt` is high.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a one-cycle-latency
// synchronous memory. Owns the program counter, keeps at most two fetched
// words (buffered plus in flight), and hands instructions to the decoder
// over a valid/ready handshake. Supports branch redirect and a global halt.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_halt,
    output logic [15:0] o_memory_address,
    output logic        o_memory_re,
    input  logic [15:0] i_memory_data,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc
);

    // Fetch-side state
    logic [15:0] pc_reg;
    logic        inflight_reg;
    logic [15:0] inflight_pc_reg;
    logic        drop_reg;

    // Prefetch buffer bookkeeping
    logic [1:0]  count_reg, count_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic        wr_ptr_reg, wr_ptr_next;

    // Per-cycle control
    logic        advance;
    logic        pop;
    logic        issue;
    logic        capture;
    logic [2:0]  credit;

    // Everything freezes while halted, in lockstep with the memory clock gate.
    assign advance = ~i_halt;

    assign o_instr_valid = (count_reg != 2'd0) & ~i_halt;
    assign pop           = o_instr_valid & i_instr_ready;

    // Words already owned (buffered + in flight) after this cycle's pop.
    // A new read is only issued when it is sure to find a free slot.
    assign credit = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

    // Reset is folded in so no read strobe escapes while reset is held.
    assign issue = ~i_reset & ~i_halt & ~i_redirect & (credit < 3'd2);

    assign o_memory_re      = issue;
    assign o_memory_address = pc_reg;

    // The word returning this cycle is kept unless a redirect discards it.
    assign capture = advance & inflight_reg & ~drop_reg & ~i_redirect;

    // Program counter and in-flight tracking.
    // A redirect never issues in the same cycle, so the in-flight word at the
    // redirect edge is simply not captured and nothing is left outstanding;
    // drop therefore only ever clears here and stays as a safety net.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= RESET_PC;
            drop_reg        <= 1'b0;
        end else if (advance) begin
            if (i_redirect) begin
                pc_reg <= i_redirect_pc;
            end else if (issue) begin
                pc_reg <= pc_reg + 16'd1;
            end
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= pc_reg;
            end
            if (inflight_reg) begin
                drop_reg <= 1'b0;
            end
        end
    end

    // Next-state for buffer occupancy and pointers; redirect flushes all.
    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (advance) begin
            if (i_redirect) begin
                count_next  = 2'd0;
                rd_ptr_next = 1'b0;
                wr_ptr_next = 1'b0;
            end else begin
                if (capture) begin
                    wr_ptr_next = ~wr_ptr_reg;
                end
                if (pop) begin
                    rd_ptr_next = ~rd_ptr_reg;
                end
                count_next = count_reg + {1'b0, capture} - {1'b0, pop};
            end
        end
    end

    // Buffer occupancy and pointer registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // One storage slot per buffer entry, written when selected by wr_ptr.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
        localparam logic SLOT = 1'(gi);
        logic [15:0] entry_pc_reg;
        logic [15:0] entry_instr_reg;

        // Capture the returning word and its address into this slot.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                entry_pc_reg    <= 16'h0000;
                entry_instr_reg <= 16'h0000;
            end else if (capture && (wr_ptr_reg == SLOT)) begin
                entry_pc_reg    <= inflight_pc_reg;
                entry_instr_reg <= i_memory_data;
            end
        end
    end

    // Head of the buffer goes to the decoder.
    always_comb begin
        o_instr    = gen_entry[0].entry_instr_reg;
        o_instr_pc = gen_entry[0].entry_pc_reg;
        if (rd_ptr_reg) begin
            o_instr    = gen_entry[1].entry_instr_reg;
            o_instr_pc = gen_entry[1].entry_pc_reg;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a behavioural
// one-cycle-latency memory holding word[a] = 16'hA000 + a.
`timescale 1ns/100ps
module tb_fetch_unit;

    logic        clk;
    logic        i_reset;

    // DUT 0 (RESET_PC = 0)
    logic        halt0, re0, valid0, ready0, redirect0;
    logic [15:0] addr0, mem_data0, instr0, instr_pc0, redirect_pc0;

    // DUT 1 (RESET_PC = FFFE), free-running with ready held high
    logic        re1, valid1;
    logic [15:0] addr1, mem_data1, instr1, instr_pc1;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(16'h0000)) dut0 (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_halt           (halt0),
        .o_memory_address (addr0),
        .o_memory_re      (re0),
        .i_memory_data    (mem_data0),
        .o_instr          (instr0),
        .o_instr_pc       (instr_pc0),
        .o_instr_valid    (valid0),
        .i_instr_ready    (ready0),
        .i_redirect       (redirect0),
        .i_redirect_pc    (redirect_pc0)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut1 (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_halt           (1'b0),
        .o_memory_address (addr1),
        .o_memory_re      (re1),
        .i_memory_data    (mem_data1),
        .o_instr          (instr1),
        .o_instr_pc       (instr_pc1),
        .o_instr_valid    (valid1),
        .i_instr_ready    (1'b1),
        .i_redirect       (1'b0),
        .i_redirect_pc    (16'h0000)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: data appears the cycle after the request edge, holds otherwise
    always @(posedge clk) begin
        if (re0) mem_data0 <= 16'hA000 + addr0;
        if (re1) mem_data1 <= 16'hA000 + addr1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance to 1 ns after the next rising edge (start of a new cycle)
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Expect a valid head carrying word at address pc
    task automatic expect_head(input string tag, input logic [15:0] pc);
        check_eq({tag, "_valid"}, valid0, 1'b1);
        check_eq({tag, "_instr"}, instr0, 16'hA000 + pc);
        check_eq({tag, "_pc"}, instr_pc0, pc);
    endtask

    // Assert reset (possibly mid-cycle), check reset outputs, release so the
    // caller's current cycle is cycle 0
    task automatic do_reset;
        i_reset = 1'b1;
        #1;
        check_eq("rst_valid", valid0, 1'b0);
        check_eq("rst_re", re0, 1'b0);
        check_eq("rst_addr", addr0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; halt0 = 1'b0; ready0 = 1'b1;
        redirect0 = 1'b0; redirect_pc0 = 16'h0000;
        mem_data0 = 16'h0000; mem_data1 = 16'h0000;
        #2;
        check_eq("rst1_addr", addr1, 16'hFFFE);

        // Reset then stream, plus wrap-around on dut1
        do_reset();
        #2;
        check_eq("s_c0_re", re0, 1'b1);
        check_eq("s_c0_addr", addr0, 16'h0000);
        check_eq("s_c0_valid", valid0, 1'b0);
        next_cycle(); #2;
        check_eq("s_c1_valid", valid0, 1'b0);
        check_eq("s_c1_addr", addr0, 16'h0001);
        next_cycle(); #2;
        expect_head("s_c2", 16'h0000);
        check_eq("w_c2_pc", instr_pc1, 16'hFFFE);
        check_eq("w_c2_instr", instr1, 16'h9FFE);
        next_cycle(); #2;
        expect_head("s_c3", 16'h0001);
        check_eq("w_c3_pc", instr_pc1, 16'hFFFF);
        check_eq("w_c3_instr", instr1, 16'h9FFF);
        next_cycle(); #2;
        expect_head("s_c4", 16'h0002);
        check_eq("w_c4_pc", instr_pc1, 16'h0000);
        check_eq("w_c4_instr", instr1, 16'hA000);
        next_cycle(); #2;
        check_eq("w_c5_valid", valid1, 1'b1);
        check_eq("w_c5_pc", instr_pc1, 16'h0001);

        // Backpressure from cycle 0
        ready0 = 1'b0;
        do_reset();
        #2;
        check_eq("bp_c0_re", re0, 1'b1);
        next_cycle(); #2;
        check_eq("bp_c1_re", re0, 1'b1);
        check_eq("bp_c1_addr", addr0, 16'h0001);
        next_cycle(); #2;
        expect_head("bp_c2", 16'h0000);
        check_eq("bp_c2_re", re0, 1'b0);
        next_cycle(); #2;
        check_eq("bp_c3_re", re0, 1'b0);
        next_cycle(); #2;
        check_eq("bp_c4_re", re0, 1'b0);
        next_cycle(); ready0 = 1'b1; #2;
        expect_head("bp_c5", 16'h0000);
        check_eq("bp_c5_re", re0, 1'b1);
        check_eq("bp_c5_addr", addr0, 16'h0002);
        next_cycle(); ready0 = 1'b0; #2;
        expect_head("bp_c6", 16'h0001);
        check_eq("bp_c6_re", re0, 1'b0);
        next_cycle(); #2;
        expect_head("bp_c7", 16'h0001);
        check_eq("bp_c7_re", re0, 1'b0);

        // Reset mid-operation with two entries buffered
        #1;
        ready0 = 1'b1;
        do_reset();
        #2;
        check_eq("mr_c0_re", re0, 1'b1);
        check_eq("mr_c0_addr", addr0, 16'h0000);
        next_cycle(); #2;
        check_eq("mr_c1_valid", valid0, 1'b0);
        next_cycle(); #2;
        expect_head("mr_c2", 16'h0000);

        // Redirect while the read of 0003 is in flight
        do_reset();
        repeat (4) next_cycle();
        redirect0 = 1'b1; redirect_pc0 = 16'h0040; #2;
        expect_head("rd_r", 16'h0002);
        check_eq("rd_r_re", re0, 1'b0);
        next_cycle(); redirect0 = 1'b0; redirect_pc0 = 16'h0000; #2;
        check_eq("rd_r1_valid", valid0, 1'b0);
        check_eq("rd_r1_re", re0, 1'b1);
        check_eq("rd_r1_addr", addr0, 16'h0040);
        next_cycle(); #2;
        check_eq("rd_r2_valid", valid0, 1'b0);
        next_cycle(); #2;
        expect_head("rd_r3", 16'h0040);
        next_cycle(); #2;
        expect_head("rd_r4", 16'h0041);

        // Halt for 5 cycles just after an issue
        do_reset();
        repeat (3) next_cycle();
        #2;
        expect_head("h_c3", 16'h0001);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); halt0 = 1'b1; #2;
            check_eq($sformatf("h_halt%0d_valid", i), valid0, 1'b0);
            check_eq($sformatf("h_halt%0d_re", i), re0, 1'b0);
        end
        next_cycle(); halt0 = 1'b0; #2;
        expect_head("h_rel0", 16'h0002);
        check_eq("h_rel0_addr", addr0, 16'h0004);
        for (int i = 1; i < 4; i++) begin
            next_cycle(); #2;
            expect_head($sformatf("h_rel%0d", i), 16'(2 + i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
